// File: rtl/noc_pkg.sv
// Shared NoC definitions: default flit geometry, field offsets, flit/credit types and the
// device-type selector used to pick the injection virtual channel.
package noc_pkg;

   localparam int unsigned FLIT_WIDTH      = 38;
   localparam int unsigned VC_BITS         = 1;
   localparam int unsigned NUM_VCS         = 2 ** VC_BITS;
   localparam int unsigned DEFAULT_CREDITS = 4;
   localparam int unsigned CREDIT_WIDTH    = $clog2(DEFAULT_CREDITS + 1);

   // Flit layout: valid | tail | dst[1:0] | vc | payload
   localparam int unsigned VALID_BIT = FLIT_WIDTH - 1;
   localparam int unsigned TAIL_BIT  = FLIT_WIDTH - 2;
   localparam int unsigned DST_HI    = FLIT_WIDTH - 3;
   localparam int unsigned DST_LO    = FLIT_WIDTH - 4;
   localparam int unsigned VC_LO     = FLIT_WIDTH - 4 - VC_BITS;

   typedef logic [FLIT_WIDTH-1:0]   flit_t;
   typedef logic [CREDIT_WIDTH-1:0] credit_t;

   typedef enum logic {DevMaster, DevSlave} device_e;

   // Lowest bit of the vc field for an arbitrary flit width.
   function automatic int unsigned vc_lo_of(int unsigned flit_width, int unsigned vc_bits);
      return flit_width - 4 - vc_bits;
   endfunction

   // Masters inject requests on VC 0, slaves inject responses on the top VC.
   function automatic int unsigned stamp_vc_of(device_e dev, int unsigned num_vcs);
      return (dev == DevSlave) ? num_vcs - 1 : 0;
   endfunction

endpackage

// File: rtl/flit_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags. DEPTH must be a power of two so the
// pointers wrap naturally. Storage is not reset; only pointers and occupancy are.
module flit_sync_fifo #(
   parameter int unsigned WIDTH = 38,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   // Pointer and occupancy update; push+pop together keeps the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage write.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/in_port_fifo.sv
// Injection buffer between an AXI4-Stream bridge and one NoC send port. Flits are queued,
// stamped with the device's VC, and injected only while that VC holds credits.
// Optional trace output is enabled by defining INPORT_FIFO_TRACE_EN.
module in_port_fifo #(
   parameter int unsigned FLIT_WIDTH        = noc_pkg::FLIT_WIDTH,
   parameter int unsigned VC_BITS           = noc_pkg::VC_BITS,
   parameter int unsigned FLIT_BUFFER_DEPTH = 4,
   parameter int unsigned FIFO_DEPTH        = 4,
   parameter string       DEVICE_TYPE       = "MASTER"
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [FLIT_WIDTH-1:0] put_flit,
   input  logic                  put_flit_valid,
   output logic                  put_flit_ready,
   output logic [FLIT_WIDTH-1:0] send_ports_putFlit_flit_in,
   output logic                  EN_send_ports_putFlit,
   input  logic [VC_BITS:0]      send_ports_getCredits,
   output logic                  EN_send_ports_getCredits
);

   import noc_pkg::*;

   localparam int unsigned NumVcs    = 2 ** VC_BITS;
   localparam int unsigned CreditW   = $clog2(FLIT_BUFFER_DEPTH + 1);
   localparam int unsigned VcLo      = vc_lo_of(FLIT_WIDTH, VC_BITS);
   localparam device_e     Dev       = (DEVICE_TYPE == "SLAVE") ? DevSlave : DevMaster;
   localparam logic [VC_BITS-1:0] StampVc = VC_BITS'(stamp_vc_of(Dev, NumVcs));
   localparam logic [CreditW-1:0] MaxCredit = CreditW'(FLIT_BUFFER_DEPTH);

   logic [FLIT_WIDTH-1:0] stamped;
   logic [FLIT_WIDTH-1:0] head;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  send;
   logic [VC_BITS-1:0]    head_vc;
   logic                  ret_valid;
   logic [VC_BITS-1:0]    ret_vc;
   logic [CreditW-1:0]    credit_q [NumVcs];
   logic [CreditW-1:0]    credit_d [NumVcs];

   assign head_vc   = head[VcLo +: VC_BITS];
   assign ret_valid = send_ports_getCredits[VC_BITS];
   assign ret_vc    = send_ports_getCredits[VC_BITS-1:0];
   assign push      = put_flit_valid && put_flit_ready;
   assign send      = !RST_N && !empty && (credit_q[head_vc] != '0);

   // Force valid and overwrite the vc field; tail, dst and payload pass through.
   always_comb begin
      stamped                    = put_flit;
      stamped[FLIT_WIDTH-1]      = 1'b1;
      stamped[VcLo +: VC_BITS]   = StampVc;
   end

   flit_sync_fifo #(
      .WIDTH (FLIT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst       (RST_N),
      .push      (push),
      .push_data (stamped),
      .pop       (send),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   // Handshake and network-side outputs, all held low while reset is asserted.
   always_comb begin
      put_flit_ready             = !RST_N && !full;
      EN_send_ports_putFlit      = send;
      EN_send_ports_getCredits   = !RST_N;
      send_ports_putFlit_flit_in = (RST_N || empty) ? '0 : head;
   end

   // Per-VC credit next state; a return saturates at the router buffer depth.
   always_comb begin
      for (int unsigned v = 0; v < NumVcs; v++) begin
         credit_d[v] = credit_q[v];
         if (ret_valid && (ret_vc == VC_BITS'(v)) && !(send && (head_vc == VC_BITS'(v)))) begin
            if (credit_q[v] != MaxCredit) credit_d[v] = credit_q[v] + CreditW'(1);
         end else if (send && (head_vc == VC_BITS'(v)) &&
                      !(ret_valid && (ret_vc == VC_BITS'(v)))) begin
            credit_d[v] = credit_q[v] - CreditW'(1);
         end
      end
   end

   // Credit counters: full depth on reset.
   always_ff @(posedge CLK) begin
      for (int unsigned v = 0; v < NumVcs; v++) begin
         if (RST_N) credit_q[v] <= MaxCredit;
         else       credit_q[v] <= credit_d[v];
      end
   end

   // A return with nothing leaving on that VC must not find the counter already full.
   always_ff @(posedge CLK) begin
      if (!RST_N && ret_valid && !(send && (head_vc == ret_vc))) begin
         assert (credit_q[ret_vc] != MaxCredit);
      end
   end

`ifdef INPORT_FIFO_TRACE_EN
   logic [15:0] cycle_q;

   // Cycle counter and event trace.
   always_ff @(posedge CLK) begin
      if (RST_N) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_q + 16'd1;
         if (send) begin
            $display("[%0d] send flit %h tail=%0b dst=%0d vc=%0d", cycle_q, head,
                     head[FLIT_WIDTH-2], head[FLIT_WIDTH-3 -: 2], head_vc);
         end
         if (ret_valid) $display("[%0d] get a credit (vc=%0d)", cycle_q, ret_vc);
         if (push) $display("[%0d] Device send flit %h", cycle_q, put_flit);
      end
   end
`endif

endmodule

// File: tb/tb_in_port_fifo.sv
// Bench for in_port_fifo: a MASTER and a SLAVE instance. Expected flits are queued when
// pushed; a negedge monitor pops and compares whenever the DUT injects.
module tb_in_port_fifo;

   import noc_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   flit_t      m_flit, m_out, s_flit, s_out;
   logic       m_valid, m_ready, m_en, m_gc;
   logic       s_valid, s_ready, s_en, s_gc;
   logic [1:0] m_cred, s_cred;

   int checks = 0;
   int errors = 0;
   int m_inj  = 0;
   int base;

   flit_t m_exp[$];
   flit_t s_exp[$];

   // Directed vectors: raw input, MASTER-stamped (vc=0), SLAVE-stamped (vc=1).
   flit_t vin [6] = '{38'h1A_12345678, 38'h00_DEADBEEF, 38'h3F_00000001,
                      38'h05_CAFEF00D, 38'h16_0F0F0F0F, 38'h29_A5A5A5A5};
   flit_t vm  [6] = '{38'h38_12345678, 38'h20_DEADBEEF, 38'h3D_00000001,
                      38'h25_CAFEF00D, 38'h34_0F0F0F0F, 38'h29_A5A5A5A5};
   flit_t vs  [6] = '{38'h3A_12345678, 38'h22_DEADBEEF, 38'h3F_00000001,
                      38'h27_CAFEF00D, 38'h36_0F0F0F0F, 38'h2B_A5A5A5A5};

   in_port_fifo #(
      .DEVICE_TYPE ("MASTER")
   ) m_dut (
      .CLK                        (clk),
      .RST_N                      (rst),
      .put_flit                   (m_flit),
      .put_flit_valid             (m_valid),
      .put_flit_ready             (m_ready),
      .send_ports_putFlit_flit_in (m_out),
      .EN_send_ports_putFlit      (m_en),
      .send_ports_getCredits      (m_cred),
      .EN_send_ports_getCredits   (m_gc)
   );

   in_port_fifo #(
      .DEVICE_TYPE ("SLAVE")
   ) s_dut (
      .CLK                        (clk),
      .RST_N                      (rst),
      .put_flit                   (s_flit),
      .put_flit_valid             (s_valid),
      .put_flit_ready             (s_ready),
      .send_ports_putFlit_flit_in (s_out),
      .EN_send_ports_putFlit      (s_en),
      .send_ports_getCredits      (s_cred),
      .EN_send_ports_getCredits   (s_gc)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one flit and wait (bounded) for ready; the push lands on the next edge.
   task automatic push(input bit slave, input flit_t f, input flit_t exp);
      int n = 0;
      if (slave) begin s_valid = 1'b1; s_flit = f; end
      else       begin m_valid = 1'b1; m_flit = f; end
      while (!(slave ? s_ready : m_ready) && n < 20) begin
         tick();
         n++;
      end
      if (slave ? s_ready : m_ready) begin
         if (slave) s_exp.push_back(exp);
         else       m_exp.push_back(exp);
      end else begin
         checks++;
         errors++;
         $display("FAIL push_timeout: got ready=0 expected ready=1 (t=%0t)", $time);
      end
      tick();
      m_valid = 1'b0;
      s_valid = 1'b0;
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (m_en) begin
         m_inj++;
         if (m_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL m_unexpected: got flit %h expected no injection (t=%0t)", m_out, $time);
         end else begin
            check("m_flit", 64'(m_out), 64'(m_exp.pop_front()));
         end
      end
      if (s_en) begin
         if (s_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL s_unexpected: got flit %h expected no injection (t=%0t)", s_out, $time);
         end else begin
            check("s_flit", 64'(s_out), 64'(s_exp.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      m_valid = 1'b0; m_flit = '0; m_cred = '0;
      s_valid = 1'b0; s_flit = '0; s_cred = '0;

      // Reset then idle.
      tick();
      check("rst_ready", m_ready, 0);
      check("rst_en", m_en, 0);
      check("rst_gc", m_gc, 0);
      check("rst_out", m_out, 0);
      tick();
      rst = 1'b0;
      tick();
      check("idle_ready", m_ready, 1);
      check("idle_gc", m_gc, 1);
      check("idle_en", m_en, 0);
      check("idle_credit0", m_dut.credit_q[0], 4);

      // Single flit: injectable the cycle after the push, credit 4 -> 3.
      push(0, vin[0], vm[0]);
      check("single_en", m_en, 1);
      check("single_out", m_out, vm[0]);
      tick();
      check("single_credit", m_dut.credit_q[0], 3);
      check("single_en_after", m_en, 0);
      m_cred = 2'b10;
      tick();
      m_cred = 2'b00;
      check("refill_credit", m_dut.credit_q[0], 4);

      // Credit exhaustion: 4 inject back to back, the 5th stalls until a return.
      base = m_inj;
      for (int i = 1; i <= 5; i++) begin
         push(0, vin[i], vm[i]);
         check($sformatf("burst_en%0d", i), m_en, 64'(i <= 4));
      end
      repeat (2) begin
         tick();
         check("stall_en", m_en, 0);
      end
      check("burst_inj", 64'(m_inj - base), 4);
      m_cred = 2'b10;
      tick();
      m_cred = 2'b00;
      check("release_en", m_en, 1);
      tick();
      check("release_en_after", m_en, 0);
      check("release_inj", 64'(m_inj - base), 5);

      // Backpressure with zero credits.
      for (int i = 0; i < 4; i++) push(0, vin[i], vm[i]);
      check("full_ready", m_ready, 0);
      m_valid = 1'b1;
      m_flit  = vin[4];
      repeat (3) begin
         tick();
         check("hold_ready", m_ready, 0);
      end
      m_cred = 2'b10;
      tick();
      m_cred = 2'b00;
      check("bp_en", m_en, 1);
      check("bp_ready_still", m_ready, 0);
      tick();
      check("bp_ready_freed", m_ready, 1);
      m_exp.push_back(vm[4]);
      tick();
      m_valid = 1'b0;
      check("bp_refull", m_ready, 0);

      // Simultaneous inject and return on VC0 keeps the count.
      m_cred = 2'b10;
      tick();
      check("sim_credit_first", m_dut.credit_q[0], 1);
      check("sim_en", m_en, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("sim_credit", m_dut.credit_q[0], 1);
      end
      m_cred = 2'b00;
      check("sim_drained_en", m_en, 0);

      // Mid-operation reset with 3 queued flits and credit 1.
      for (int i = 0; i < 4; i++) push(0, vin[i], vm[i]);
      check("pre_rst_en", m_en, 0);
      m_cred = 2'b10;
      tick();
      m_cred = 2'b00;
      check("pre_rst_credit", m_dut.credit_q[0], 1);
      check("pre_rst_en1", m_en, 1);
      rst = 1'b1;
      #1;
      check("in_rst_en", m_en, 0);
      check("in_rst_out", m_out, 0);
      check("in_rst_ready", m_ready, 0);
      tick();
      rst = 1'b0;
      m_exp.delete();
      #1;
      check("post_rst_en", m_en, 0);
      check("post_rst_ready", m_ready, 1);
      check("post_rst_credit0", m_dut.credit_q[0], 4);
      check("post_rst_credit1", m_dut.credit_q[1], 4);
      check("post_rst_out", m_out, 0);
      tick();
      tick();
      check("post_rst_idle_en", m_en, 0);

      // SLAVE stamps vc=1; inject and return on VC1 in the same cycle.
      push(1, vin[4], vs[4]);
      push(1, vin[5], vs[5]);
      check("slave_en", s_en, 1);
      s_cred = 2'b11;
      tick();
      s_cred = 2'b00;
      check("slave_credit1", s_dut.credit_q[1], 3);
      check("slave_credit0", s_dut.credit_q[0], 4);
      check("slave_en_after", s_en, 0);

      tick();
      tick();
      check("m_exp_left", 64'(m_exp.size()), 0);
      check("s_exp_left", 64'(s_exp.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/in_port_fifo.md
Name: in_port_fifo

Overview:
- Injection-side buffer between an AXI4-Stream master bridge and one send port of the credit-based NoC (mkNetwork).
- Accepts flits over a valid/ready handshake and queues them.
- Stamps the virtual channel (VC) selected by device type, then injects flits into the network only while the per-VC credit counter is non-zero.
- Absorbs credit returns from the network.

Parameters:
- FLIT_WIDTH, 38, total flit width including the valid bit.
- VC_BITS, 1, width of the VC index; NUM_VCS = 2**VC_BITS.
- FLIT_BUFFER_DEPTH, 4, credits per VC at reset (router input buffer depth).
- FIFO_DEPTH, 4, local queue entries (power of 2, ≥2).
- DEVICE_TYPE, "MASTER", "MASTER" stamps VC 0 and "SLAVE" stamps VC NUM_VCS-1 (request/response separation).

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset; name kept per codebase, synchronous, active-high (1 = reset).
- put_flit  in  FLIT_WIDTH  flit from bridge.
- put_flit_valid  in  1  bridge offers put_flit.
- put_flit_ready  out  1  queue can accept.
- send_ports_putFlit_flit_in  out  FLIT_WIDTH  flit to network.
- EN_send_ports_putFlit  out  1  network injects flit this cycle.
- send_ports_getCredits  in  VC_BITS+1  credit return; [VC_BITS]=valid, [VC_BITS-1:0]=vc.
- EN_send_ports_getCredits  out  1  credit-read enable.

Behaviour:
- Flit layout: [W-1] valid, [W-2] tail, [W-3:W-4] dst, [W-5 -: VC_BITS] vc, remainder payload.
- Reset (RST_N=1 sampled at posedge):
  - Queue emptied; every credit counter = FLIT_BUFFER_DEPTH.
  - While reset is held: put_flit_ready=0, EN_send_ports_putFlit=0, EN_send_ports_getCredits=0, send_ports_putFlit_flit_in=0.
- Reset asserted mid-operation discards queued flits and restores all credits on the next edge.
- Input handshake: put_flit_ready = !full, registered state only (no dependence on a same-cycle pop). A push occurs when valid && ready.
- VC stamping on push: the vc field is overwritten per DEVICE_TYPE and the valid bit is forced to 1. Tail, dst and payload are untouched.
- Injection:
  - EN_send_ports_putFlit = !empty && credit[head.vc] != 0.
  - send_ports_putFlit_flit_in = head entry whenever not empty, else 0.
  - On enable: pop the head and decrement credit[head.vc].
- Latency: a flit pushed at edge t is injectable at the earliest in the cycle after t (one cycle; no bypass). Back-to-back injection is 1 flit/cycle while credits last.
- Credits:
  - EN_send_ports_getCredits=1 every cycle out of reset.
  - When getCredits[VC_BITS]=1, increment credit[vc].
  - A same-cycle return and injection on the same VC leaves the count unchanged.
- Counters are $clog2(FLIT_BUFFER_DEPTH+1) bits and never exceed FLIT_BUFFER_DEPTH. A return at maximum is ignored and fires a simulation assertion.
- Full and empty: a simultaneous push and pop when full is not possible (ready=0). A simultaneous push and pop at any other occupancy keeps the count. Pointers wrap modulo FIFO_DEPTH.
- Order: strict FIFO; the head blocks while its VC has zero credits (no reordering).

Optional Feature:
- INPORT_FIFO_TRACE_EN defined: each posedge $display of the cycle count plus:
  - "send flit" with the flit, tail, dst and vc when injecting;
  - "get a credit (vc=..)" on a valid return;
  - "Device send flit" on an input handshake.
  - The cycle counter is 16-bit, counting from reset.
- Undefined: no display code and no cycle counter; the data path is identical.

Decomposition:
- Shared package (noc_pkg):
  - FLIT_WIDTH, VC_BITS and field offset constants (VALID_BIT, TAIL_BIT, DST_HI/LO, VC_LO);
  - typedefs flit_t and credit_t;
  - device-type enum.
- One sub-module, flit_sync_fifo: a parameterized depth/width synchronous FIFO with full/empty flags.

Test Plan:
- Reset then idle: all outputs match the reset values; after release put_flit_ready=1 and EN_send_ports_getCredits=1, with no injection.
- Single flit, MASTER: push a flit with vc bit 1, dst=2, tail=1. The next cycle EN_send_ports_putFlit=1, the flit is unchanged except vc=0 and valid=1, and credit[0] goes 4→3.
- Credit exhaustion: push 5 flits with no returns. Exactly 4 inject on consecutive cycles and the 5th stalls. Return credit vc=0 and the 5th injects the following cycle.
- Backpressure: with credits held at 0, push 4 flits. put_flit_ready drops to 0 after the 4th push, and a 5th valid is not accepted until a pop frees an entry.
- Simultaneous events: inject on VC0 and return credit vc=0 in the same cycle; credit[0] stays at its value. Do the same with DEVICE_TYPE="SLAVE" and confirm flits carry vc=1.
- Mid-operation reset: with 3 queued flits and credit[0]=1, assert RST_N for 1 cycle. The queue is empty, credit=4, and no injection occurs.
